// File: rtl/spi_slave_tx_sched.sv
// spi_slave_tx_sched
// Shares one SPI slave byte transmitter among N byte-stream sources. Each
// chip-select transaction grants one eligible source (round robin), streams
// its len-byte frame into the transmitter, then pads with FILL until CS rises.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   spi_cs_n       raw SPI chip select (async to clk)
//   req, len       per-source request level and frame length (byte i = len[8i+:8])
//   rd_data, rd_en per-source FWFT byte and one-cycle pop strobe
//   grant          one-hot grant held for the frame
//   done, abort    one-cycle per-source completion / CS-released-early pulses
//   txd_en         start strobe to the transmitter (START state)
//   txd_data       byte offered to the transmitter
//   txd_over       transmitter: byte shifted, next byte sampled this cycle
//   busy           FSM not in IDLE
module spi_slave_tx_sched #(
  parameter int         N    = 4,
  parameter logic [7:0] FILL = 8'hFF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           spi_cs_n,
  input  logic [N-1:0]   req,
  input  logic [N*8-1:0] len,
  input  logic [N*8-1:0] rd_data,
  output logic [N-1:0]   rd_en,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   done,
  output logic [N-1:0]   abort,
  output logic           txd_en,
  output logic [7:0]     txd_data,
  input  logic           txd_over,
  output logic           busy
);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {IDLE, ARB, START, STREAM} state_e;

  state_e        state_q, state_d;
  logic [1:0]    cs_sync_q;
  logic          cs_prev_q;
  logic [IW-1:0] rr_q, rr_d, k_q, k_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [7:0]    len_q, len_d, txd_data_q, txd_data_d;
  logic [8:0]    rem_q, rem_d, sent_q, sent_d;
  logic [1:0]    tmr_q, tmr_d;
  logic          ld_q, ld_d;      // fetch the next byte one cycle after a sample
  logic          txd_en_q, txd_en_d;

  logic cs_s, cs_fall, cs_rise;
  assign cs_s    = cs_sync_q[1];
  assign cs_fall = cs_prev_q & ~cs_s;
  assign cs_rise = ~cs_prev_q & cs_s;

  // Round-robin winner: scan offsets N..1 so the smallest offset from rr+1 wins.
  logic [N-1:0]  elig;
  logic          win_vld;
  logic [IW-1:0] win_idx, cand;
  always_comb begin
    for (int i = 0; i < N; i++) elig[i] = req[i] && (len[8*i +: 8] != 8'd0);
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int o = N; o >= 1; o--) begin
      cand = IW'((int'(rr_q) + o) % N);
      if (elig[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Sample event: first-sample timer expiry or a transmitter txd_over.
  logic samp, fin;
  assign samp = (state_q == STREAM) && ((tmr_q == 2'd1) || txd_over);
  // Frame completion; txd_over is counted before a coincident cs_rise.
  assign fin  = (state_q == STREAM) && txd_over && (grant_q != '0) &&
                (sent_q + 9'd1 == {1'b0, len_q});

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    k_d        = k_q;
    grant_d    = grant_q;
    len_d      = len_q;
    txd_data_d = txd_data_q;
    rem_d      = rem_q;
    sent_d     = sent_q;
    tmr_d      = tmr_q;
    ld_d       = 1'b0;
    txd_en_d   = 1'b0;
    rd_en      = '0;
    done       = '0;
    abort      = '0;
    case (state_q)
      IDLE: if (cs_fall) state_d = ARB;
      ARB: begin
        if (win_vld) begin
          grant_d        = N'(1) << win_idx;
          rr_d           = win_idx;
          k_d            = win_idx;
          len_d          = len[{win_idx, 3'b000} +: 8];
          rem_d          = {1'b0, len[{win_idx, 3'b000} +: 8]};
          sent_d         = '0;
          txd_data_d     = rd_data[{win_idx, 3'b000} +: 8];
          rd_en[win_idx] = 1'b1;
        end else begin
          grant_d    = '0;
          txd_data_d = FILL;
        end
        txd_en_d = 1'b1;   // registered: high during START
        state_d  = START;
      end
      START: begin
        tmr_d   = 2'd2;
        state_d = STREAM;
      end
      STREAM: begin
        if (tmr_q != 2'd0) tmr_d = tmr_q - 2'd1;
        if (samp) begin
          ld_d = 1'b1;
          if (rem_q != 9'd0) rem_d = rem_q - 9'd1;
        end
        if (ld_q) begin
          if (rem_q != 9'd0 && grant_q != '0) begin
            txd_data_d = rd_data[{k_q, 3'b000} +: 8];
            rd_en[k_q] = 1'b1;
          end else begin
            txd_data_d = FILL;
          end
        end
        if (txd_over && grant_q != '0) sent_d = sent_q + 9'd1;
        if (fin) begin
          done[k_q] = 1'b1;
          grant_d   = '0;
        end
        if (cs_rise) begin
          if (grant_q != '0 && !fin) abort[k_q] = 1'b1;
          rd_en      = '0;
          grant_d    = '0;
          txd_data_d = FILL;
          ld_d       = 1'b0;
          tmr_d      = 2'd0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cs_sync_q  <= 2'b11;
      cs_prev_q  <= 1'b1;
      rr_q       <= IW'(N-1);
      k_q        <= '0;
      grant_q    <= '0;
      len_q      <= '0;
      txd_data_q <= FILL;
      rem_q      <= '0;
      sent_q     <= '0;
      tmr_q      <= '0;
      ld_q       <= 1'b0;
      txd_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cs_sync_q  <= {cs_sync_q[0], spi_cs_n};
      cs_prev_q  <= cs_sync_q[1];
      rr_q       <= rr_d;
      k_q        <= k_d;
      grant_q    <= grant_d;
      len_q      <= len_d;
      txd_data_q <= txd_data_d;
      rem_q      <= rem_d;
      sent_q     <= sent_d;
      tmr_q      <= tmr_d;
      ld_q       <= ld_d;
      txd_en_q   <= txd_en_d;
    end
  end

  assign grant    = grant_q;
  assign txd_data = txd_data_q;
  assign txd_en   = txd_en_q;
  assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_spi_slave_tx_sched.sv
// Bench for spi_slave_tx_sched: FWFT source models, a transmitter model that
// samples txd_data 2 cycles after txd_en and on every txd_over, and a
// frame-level reference (round-robin pick, byte list, done/abort/pop counts).
module tb_spi_slave_tx_sched;
  localparam int         N    = 4;
  localparam logic [7:0] FILL = 8'hFF;

  logic           clk = 1'b0, rst_n = 1'b0, spi_cs_n = 1'b1, txd_over = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*8-1:0] len = '0;
  logic [N*8-1:0] rd_data;
  logic [N-1:0]   rd_en, grant, done, abort;
  logic           txd_en, busy;
  logic [7:0]     txd_data;

  always #5 clk = ~clk;

  spi_slave_tx_sched #(.N(N), .FILL(FILL)) dut (
    .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .req(req), .len(len),
    .rd_data(rd_data), .rd_en(rd_en), .grant(grant), .done(done),
    .abort(abort), .txd_en(txd_en), .txd_data(txd_data),
    .txd_over(txd_over), .busy(busy)
  );

  // Source FIFOs: head = pops since the last reload.
  logic [7:0]   mem [N][16];
  int           pop_total [N];
  int           base [N];
  logic [N-1:0] pop_pend = '0;
  int           idx;
  always_comb begin
    idx = 0;
    for (int i = 0; i < N; i++) begin
      idx = pop_total[i] - base[i];
      rd_data[8*i +: 8] = mem[i][idx[3:0]];
    end
  end
  always @(posedge clk)
    for (int i = 0; i < N; i++) if (pop_pend[i]) pop_total[i] <= pop_total[i] + 1;

  int tests = 0, fails = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference state
  int         m_rr, m_k, m_len, m_nsamp, m_nover, m_ntxen, c_done, c_abort, c_pops, j;
  int         last_done, last_abort, last_pops, exp_pops;
  logic [1:0] en_h;
  logic       prev_busy;
  logic [7:0] exp_b;
  logic [N-1:0] exp_d;
  int         hist[$];
  logic [7:0] smp[$];

  task automatic set_src(input int i, input logic [7:0] l,
                         input logic [7:0] b0, b1, b2, b3);
    len[8*i +: 8] = l;
    mem[i][0] = b0; mem[i][1] = b1; mem[i][2] = b2; mem[i][3] = b3;
    base[i] = pop_total[i];
  endtask

  // One CS transaction: n_over txd_over pulses, then CS release (optionally
  // with a final txd_over landing on the synchronised rising edge).
  task automatic xact(input int n_over, input bit coincide);
    for (int i = 0; i < N; i++) base[i] = pop_total[i];
    @(posedge clk); #1 spi_cs_n = 1'b0;
    repeat (12) @(posedge clk);
    for (int i = 0; i < n_over; i++) begin
      #1 txd_over = 1'b1;
      @(posedge clk); #1 txd_over = 1'b0;
      repeat (5) @(posedge clk);
    end
    #1 spi_cs_n = 1'b1;
    if (coincide) begin
      @(posedge clk); @(posedge clk);
      #1 txd_over = 1'b1;
      @(posedge clk); #1 txd_over = 1'b0;
    end else begin
      repeat (3) @(posedge clk);
    end
    @(negedge clk);
    chk("idle_3cyc", {grant, busy}, '0);
    repeat (4) @(posedge clk);
  endtask

  task automatic chk_reset_vals(input string name);
    chk(name, {grant, done, abort, rd_en, txd_en, busy, txd_data},
        {{(4*N){1'b0}}, 2'b00, FILL});
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          m_rr = N-1; m_k = -1; m_len = 0; m_nsamp = 0; m_nover = 0; m_ntxen = 0;
          c_done = 0; c_abort = 0; c_pops = 0; en_h = '0; prev_busy = 1'b0;
          pop_pend = '0;
        end else begin
          pop_pend = rd_en;
          chk("pulse_rules", {$onehot0(rd_en), $onehot0(done), $onehot0(abort),
              busy || (rd_en == '0 && done == '0 && abort == '0)}, 4'b1111);
          if (txd_en) begin
            m_k = -1;
            for (int o = 1; o <= N; o++) begin
              j = (m_rr + o) % N;
              if (m_k < 0 && req[j] && len[8*j +: 8] != 8'd0) m_k = j;
            end
            chk("grant", grant, (m_k >= 0) ? (32'd1 << m_k) : 32'd0);
            hist.push_back(m_k);
            if (m_k >= 0) begin m_rr = m_k; m_len = int'(len[8*m_k +: 8]); end
            m_nsamp = 0; m_nover = 0; smp.delete(); m_ntxen++;
          end
          if (en_h[1] || txd_over) begin
            exp_b = (m_k >= 0 && m_nsamp < m_len) ? mem[m_k][m_nsamp[3:0]] : FILL;
            chk("txd_data", txd_data, exp_b);
            smp.push_back(txd_data);
            m_nsamp++;
          end
          en_h = {en_h[0], txd_en};
          exp_d = '0;
          if (txd_over && m_k >= 0 && m_nover < m_len) begin
            if (m_nover + 1 == m_len) exp_d[m_k] = 1'b1;
            m_nover++;
          end
          chk("done", done, exp_d);
          if (done != '0) c_done++;
          if (abort != '0) c_abort++;
          c_pops += $countones(rd_en);
          if (prev_busy && !busy) begin
            exp_pops = (m_k < 0) ? 0 : ((m_len < 1 + m_nsamp) ? m_len : 1 + m_nsamp);
            chk("txd_en_once", m_ntxen, 1);
            chk("done_count", c_done, (m_k >= 0 && m_nover >= m_len) ? 1 : 0);
            chk("abort_count", c_abort, (m_k >= 0 && m_nover < m_len) ? 1 : 0);
            chk("pop_count", c_pops, exp_pops);
            last_done = c_done; last_abort = c_abort; last_pops = c_pops;
            c_done = 0; c_abort = 0; c_pops = 0; m_ntxen = 0;
          end
          prev_busy = busy;
        end
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset_vals");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Round robin from reset: 0,1,2,3
    for (int i = 0; i < N; i++) set_src(i, 8'd1, 8'h10 + 8'(i), 8'h20, 8'h30, 8'h40);
    req = 4'b1111;
    for (int t = 0; t < 4; t++) xact(1, 1'b0);
    for (int t = 0; t < 4; t++) chk("rr_order", hist[hist.size()-4+t], t);

    // Frame transfer: source 1, 3 bytes, 5 bytes on the wire
    req = 4'b0010;
    set_src(1, 8'd3, 8'hA5, 8'h3C, 8'h0F, 8'h77);
    xact(4, 1'b0);
    chk("frame_grant", hist[hist.size()-1], 1);
    chk("frame_nbytes", smp.size(), 5);
    chk("frame_bytes", {smp[0], smp[1], smp[2], smp[3], smp[4]}, 40'hA53C0FFFFF);
    chk("frame_pops", last_pops, 3);
    chk("frame_done", last_done, 1);

    // Abort: source 0, len 4, CS released after 2 bytes shifted
    req = 4'b0001;
    set_src(0, 8'd4, 8'h11, 8'h22, 8'h33, 8'h44);
    xact(2, 1'b0);
    chk("abort_pulse", {last_abort[7:0], last_done[7:0]}, 16'h0100);
    chk("abort_bytes", {smp[0], smp[1], smp[2]}, 24'h112233);

    // No eligible source: len 0, then no request at all
    req = 4'b0100;
    set_src(2, 8'd0, 8'h55, 8'h66, 8'h77, 8'h88);
    xact(2, 1'b0);
    chk("noelig_grant", hist[hist.size()-1], -1);
    chk("noelig_pops", last_pops, 0);
    chk("noelig_bytes", {smp[0], smp[1], smp[2]}, 24'hFFFFFF);
    req = 4'b0000;
    xact(1, 1'b0);
    chk("noreq_grant", hist[hist.size()-1], -1);

    // Coincident final txd_over and cs_rise, 2-byte frame on source 2
    req = 4'b0100;
    set_src(2, 8'd2, 8'hC1, 8'hC2, 8'hC3, 8'hC4);
    xact(1, 1'b1);
    chk("coinc_grant", hist[hist.size()-1], 2);
    chk("coinc_done_abort", {last_done[7:0], last_abort[7:0]}, 16'h0100);

    // Mid-frame reset, then arbitration restarts at source 0
    req = 4'b1111;
    for (int i = 0; i < N; i++) set_src(i, 8'd2, 8'hD0 + 8'(i), 8'hE0, 8'hE1, 8'hE2);
    @(posedge clk); #1 spi_cs_n = 1'b0;
    repeat (12) @(posedge clk);
    #1 txd_over = 1'b1;
    @(posedge clk); #1 txd_over = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0; spi_cs_n = 1'b1;
    #1 chk_reset_vals("reset_async");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    xact(1, 1'b0);
    chk("post_reset_grant", hist[hist.size()-1], 0);
    chk("post_reset_byte", smp[0], 8'hD0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
